// File: rtl/mux7_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux7_rr_arbiter
// Function : Round-robin arbiter driving the select of a 7-input 24-bit mux.
//            Optional hold-time limit enabled by defining ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mux7_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] req,
  input  logic       done,
  output logic [6:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Returns {found, index}: first set request at or after base, wrapping 6->0.
  function automatic logic [3:0] f_arbitrate(input logic [6:0] r, input logic [2:0] base);
    logic [3:0] res;
    logic [3:0] sum;
    logic [2:0] idx;
    res = 4'b0000;
    for (int k = 6; k >= 0; k--) begin
      sum = {1'b0, base} + 4'(k);
      idx = (sum >= 4'd7) ? 3'(sum - 4'd7) : sum[2:0];
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [2:0] f_next_idx(input logic [2:0] i);
    return (i >= 3'd6) ? 3'd0 : i + 3'd1;
  endfunction

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_ptr;
  logic [2:0] w_ptr_nxt;
  logic [6:0] r_gnt;
  logic [6:0] w_gnt_nxt;
  logic [2:0] r_sel;
  logic [2:0] w_sel_nxt;
  logic       w_to_nxt;

  logic       w_norm_rel;
  logic       w_force;
  logic       w_release;
  logic [2:0] w_base;
  logic [3:0] w_arb;

  // The owner index is carried by r_sel: whenever a grant is active they match.
  assign w_norm_rel = done | ~req[r_sel];
  assign w_release  = (r_state == ST_GRANT) & (w_norm_rel | w_force);
  assign w_base     = (r_state == ST_GRANT) ? f_next_idx(r_sel) : r_ptr;
  assign w_arb      = f_arbitrate(req, w_base);

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);

  logic [7:0] r_cnt;
  logic       r_timeout;
  logic       w_load;

  assign w_force = (r_state == ST_GRANT) & (r_cnt == c_max_hold) & ~w_norm_rel;
  assign w_load  = w_arb[3] & ((r_state == ST_IDLE) | w_release);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_to_nxt;
      if (w_load) begin
        r_cnt <= 8'd1;
      end else if (r_state == ST_GRANT) begin
        r_cnt <= (w_state_nxt == ST_IDLE) ? 8'd0 : r_cnt + 8'd1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  assign w_force = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_to_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb[3]) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = 7'd1 << w_arb[2:0];
          w_sel_nxt   = w_arb[2:0];
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_ptr_nxt = w_base;
          w_to_nxt  = w_force;
          if (w_arb[3]) begin
            w_gnt_nxt = 7'd1 << w_arb[2:0];
            w_sel_nxt = w_arb[2:0];
          end else begin
            // Select holds its last value so the mux output stays stable.
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = 7'd0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 7'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= 3'd0;
      r_gnt   <= 7'd0;
      r_sel   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  assign gnt  = r_gnt;
  assign sel  = r_sel;
  assign busy = |r_gnt;

endmodule
`default_nettype wire

// File: tb/tb_mux7_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux7_rr_arbiter
// Function : Directed scoreboard bench for mux7_rr_arbiter (MAX_HOLD=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux7_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [6:0] req;
  logic       done;
  logic [6:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       timeout;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [6:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       tout;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  mux7_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: after every rising edge, compare outputs against the next expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (gnt !== e.gnt || sel !== e.sel || busy !== e.busy || timeout !== e.tout) begin
        n_fail++;
        $display("FAIL %s: got gnt=%b sel=%0d busy=%b timeout=%b, want gnt=%b sel=%0d busy=%b timeout=%b",
                 e.name, gnt, sel, busy, timeout, e.gnt, e.sel, e.busy, e.tout);
      end
    end
  end

  task automatic step(input logic [6:0] r, input logic d, input logic [6:0] eg,
                      input logic [2:0] es, input logic eb, input logic et, input string nm);
    exp_t e;
    @(negedge clk);
    req  = r;
    done = d;
    e.gnt = eg; e.sel = es; e.busy = eb; e.tout = et; e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic check_reset_state(input string nm);
    n_checks++;
    if (gnt !== 7'd0 || sel !== 3'd0 || busy !== 1'b0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got gnt=%b sel=%0d busy=%b timeout=%b, want all zero",
               nm, gnt, sel, busy, timeout);
    end
  endtask

  // Called right after a rising edge; asserts reset mid-cycle, checks before next edge.
  task automatic async_reset(input string nm);
    #3;
    rst  = 1'b1;
    req  = 7'd0;
    done = 1'b0;
    #1;
    check_reset_state(nm);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b1;
    req  = 7'd0;
    done = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("power_on_reset");
    rst = 1'b0;

    // Single requester 3, grant then release with done.
    step(7'h08, 1'b0, 7'h08, 3'd3, 1'b1, 1'b0, "single_req3_grant");
    step(7'h08, 1'b0, 7'h08, 3'd3, 1'b1, 1'b0, "single_req3_hold");
    step(7'h00, 1'b1, 7'h00, 3'd3, 1'b0, 1'b0, "single_req3_release");
    step(7'h00, 1'b0, 7'h00, 3'd3, 1'b0, 1'b0, "idle_sel_held");
    step(7'h00, 1'b1, 7'h00, 3'd3, 1'b0, 1'b0, "done_in_idle_ignored");
    // ptr=4: sole requester 3 wins again, even right after its own release.
    step(7'h08, 1'b0, 7'h08, 3'd3, 1'b1, 1'b0, "req3_regrant");
    step(7'h08, 1'b1, 7'h08, 3'd3, 1'b1, 1'b0, "sole_owner_rewins");
    step(7'h08, 1'b0, 7'h08, 3'd3, 1'b1, 1'b0, "sole_owner_hold");
    async_reset("async_reset_mid_grant");

    // All requesting, done every cycle: rotate 0..6 then wrap to 0 without a bubble.
    step(7'h7F, 1'b1, 7'h01, 3'd0, 1'b1, 1'b0, "rot_0");
    step(7'h7F, 1'b1, 7'h02, 3'd1, 1'b1, 1'b0, "rot_1");
    step(7'h7F, 1'b1, 7'h04, 3'd2, 1'b1, 1'b0, "rot_2");
    step(7'h7F, 1'b1, 7'h08, 3'd3, 1'b1, 1'b0, "rot_3");
    step(7'h7F, 1'b1, 7'h10, 3'd4, 1'b1, 1'b0, "rot_4");
    step(7'h7F, 1'b1, 7'h20, 3'd5, 1'b1, 1'b0, "rot_5");
    step(7'h7F, 1'b1, 7'h40, 3'd6, 1'b1, 1'b0, "rot_6");
    step(7'h7F, 1'b1, 7'h01, 3'd0, 1'b1, 1'b0, "rot_wrap_0");
    step(7'h00, 1'b1, 7'h00, 3'd0, 1'b0, 1'b0, "rot_release_idle");

    // ptr=1: owner 2, requester 5 must not preempt; handover on req[2] drop.
    step(7'h04, 1'b0, 7'h04, 3'd2, 1'b1, 1'b0, "owner2_grant");
    step(7'h24, 1'b0, 7'h04, 3'd2, 1'b1, 1'b0, "owner2_no_preempt_a");
    step(7'h24, 1'b0, 7'h04, 3'd2, 1'b1, 1'b0, "owner2_no_preempt_b");
    step(7'h20, 1'b0, 7'h20, 3'd5, 1'b1, 1'b0, "handover_to_5");
    step(7'h00, 1'b0, 7'h00, 3'd5, 1'b0, 1'b0, "owner5_drop_idle");

    @(posedge clk);
    async_reset("async_reset_idle");

    // ptr=0: grant 4; release advances ptr to 5 so 0 beats 4.
    step(7'h10, 1'b0, 7'h10, 3'd4, 1'b1, 1'b0, "only4_grant");
    step(7'h10, 1'b0, 7'h10, 3'd4, 1'b1, 1'b0, "only4_hold");
    step(7'h11, 1'b1, 7'h01, 3'd0, 1'b1, 1'b0, "ptr5_picks_0");
    step(7'h00, 1'b1, 7'h00, 3'd0, 1'b0, 1'b0, "owner0_release");

    @(posedge clk);
    async_reset("async_reset_pre_timeout");

    // Owner 1 hogs with requester 6 waiting; MAX_HOLD=4.
    step(7'h42, 1'b0, 7'h02, 3'd1, 1'b1, 1'b0, "hog_c1");
    step(7'h42, 1'b0, 7'h02, 3'd1, 1'b1, 1'b0, "hog_c2");
    step(7'h42, 1'b0, 7'h02, 3'd1, 1'b1, 1'b0, "hog_c3");
    step(7'h42, 1'b0, 7'h02, 3'd1, 1'b1, 1'b0, "hog_c4");
`ifdef ARB_TIMEOUT_EN
    step(7'h42, 1'b0, 7'h40, 3'd6, 1'b1, 1'b1, "forced_handover_6");
    step(7'h42, 1'b0, 7'h40, 3'd6, 1'b1, 1'b0, "timeout_pulse_ends");
    step(7'h00, 1'b0, 7'h00, 3'd6, 1'b0, 1'b0, "after_timeout_idle");
`else
    step(7'h42, 1'b0, 7'h02, 3'd1, 1'b1, 1'b0, "hold_past_limit_a");
    step(7'h42, 1'b0, 7'h02, 3'd1, 1'b1, 1'b0, "hold_past_limit_b");
    step(7'h00, 1'b0, 7'h00, 3'd1, 1'b0, 1'b0, "hog_release_idle");
`endif

    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want normal completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
